// File: rtl/pkg_npu_loader.sv
// Shared types and constants for the NPU activation loader:
// FSM states, register-map offsets and STATUS bit positions.
package pkg_npu_loader;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StWait   = 2'd2
    } loader_state_e;

    localparam logic [1:0] TypeOff   = 2'd0;
    localparam logic [1:0] InputOff  = 2'd1;
    localparam logic [1:0] ResultOff = 2'd2;
    localparam logic [1:0] StatusOff = 2'd3;

    localparam int StartBit   = 31;
    localparam int StBusyBit  = 0;
    localparam int StDoneBit  = 1;
    localparam int StFullBit  = 2;
    localparam int StEmptyBit = 3;
    localparam int StOvfBit   = 4;
    localparam int StCntLsb   = 8;

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module npu_sync_fifo #(
    parameter int DWidth = 32,
    parameter int Depth  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DWidth-1:0]        wdata_i,
    output logic [DWidth-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int AW   = $clog2(Depth);
    localparam int CntW = AW + 1;

    logic [DWidth-1:0] mem_q [Depth];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/npu_act_loader.sv
// Bus-side activation loader: buffers written words, streams a job of LEN
// words to the compute core, then captures the core's result for readback.
module npu_act_loader
    import pkg_npu_loader::*;
#(
    parameter int DWidth   = 32,
    parameter int Depth    = 16,
    parameter int LenWidth = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wen_type_i,
    input  logic              wen_input_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              act_valid_o,
    output logic [DWidth-1:0] act_data_o,
    output logic              act_last_o,
    input  logic              act_ready_i,
    input  logic              res_valid_i,
    input  logic [DWidth-1:0] res_data_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CntW = $clog2(Depth) + 1;

    loader_state_e       state_q, state_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] rem_q, rem_d;
    logic [DWidth-1:0]   result_q, result_d;
    logic [DWidth-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [DWidth-1:0]   fifo_head;
    logic [CntW-1:0]     fifo_count;
    logic [1:0]          off;
    logic                start_req, result_read;
    logic [DWidth-1:0]   status;
    logic                unused_bits;

    assign off         = addr_i[3:2];
    assign unused_bits = ^{addr_i[DWidth-1:4], addr_i[1:0], wdata_i[StartBit-1:LenWidth]};

    npu_sync_fifo #(
        .DWidth (DWidth),
        .Depth  (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wen_input_i),
        .pop_i   (fifo_pop),
        .wdata_i (wdata_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Stream side is combinational from the FIFO head; popping only on the
    // handshake keeps valid/data stable under back-pressure.
    assign act_valid_o = (state_q == StStream) && !fifo_empty;
    assign act_data_o  = act_valid_o ? fifo_head : '0;
    assign act_last_o  = act_valid_o && (rem_q == LenWidth'(1));
    assign fifo_pop    = act_valid_o && act_ready_i;

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

    assign start_req   = wdata_i[StartBit] && (wdata_i[LenWidth-1:0] != '0);
    assign result_read = (off == ResultOff) && !wen_type_i && !wen_input_i && done_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (wen_type_i) begin
                    len_d = wdata_i[LenWidth-1:0];
                    ovf_d = 1'b0;
                    if (start_req) begin
                        rem_d   = wdata_i[LenWidth-1:0];
                        done_d  = 1'b0;
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (fifo_pop) begin
                    rem_d = rem_q - LenWidth'(1);
                    if (rem_q == LenWidth'(1)) state_d = StWait;
                end
            end
            StWait: begin
                if (res_valid_i) begin
                    result_d = res_data_i;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (wen_input_i && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (result_read) done_d = 1'b0;
    end

    always_comb begin
        status                   = '0;
        status[StBusyBit]        = busy_o;
        status[StDoneBit]        = done_q;
        status[StFullBit]        = fifo_full;
        status[StEmptyBit]       = fifo_empty;
        status[StOvfBit]         = ovf_q;
        status[StCntLsb +: 8]    = 8'(fifo_count);
    end

    always_comb begin
        rdata_d = '0;
        case (off)
            TypeOff:   rdata_d = DWidth'(len_q);
            InputOff:  rdata_d = '0;
            ResultOff: rdata_d = result_q;
            StatusOff: rdata_d = status;
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            len_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_npu_act_loader.sv
// Scenario bench for npu_act_loader: expected streams come from queues of
// the words pushed, expected STATUS words from plain arithmetic.
module tb_npu_act_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen_type, wen_input, act_ready, res_valid;
    logic [DW-1:0] addr, wdata, res_data, rdata, act_data;
    logic          act_valid, act_last, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] got_d[$];
    bit          got_l[$];

    always #5 clk = ~clk;

    npu_act_loader #(.DWidth(DW), .Depth(DEPTH), .LenWidth(LW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wen_type_i  (wen_type),
        .wen_input_i (wen_input),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .act_valid_o (act_valid),
        .act_data_o  (act_data),
        .act_last_o  (act_last),
        .act_ready_i (act_ready),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen_type = 0; wen_input = 0; addr = 32'hC; wdata = 0;
        act_ready = 0; res_valid = 0; res_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; next(); next(); rst = 0;
    endtask

    task automatic write_type(input logic [31:0] v);
        wen_type = 1; wdata = v; addr = 32'h0; next();
        wen_type = 0; addr = 32'hC;
    endtask

    task automatic push(input logic [31:0] v);
        wen_input = 1; wdata = v; addr = 32'h4; next();
        wen_input = 0; addr = 32'hC;
    endtask

    task automatic read_reg(input int off, output logic [31:0] v);
        addr = 32'(off * 4); next();
        v = rdata; addr = 32'hC;
    endtask

    task automatic finish_job(input logic [31:0] r);
        res_valid = 1; res_data = r; next();
        res_valid = 0;
    endtask

    // Gathers accepted stream words; ready is either held high or random.
    task automatic collect(input int n, input bit rnd);
        got_d.delete(); got_l.delete();
        for (int c = 0; c < 400 && got_d.size() < n; c++) begin
            act_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (act_valid && act_ready) begin
                got_d.push_back(act_data);
                got_l.push_back(act_last);
            end
            next();
        end
        act_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; next();
        n_total++; if (rdata !== 0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
        n_total++; if ({act_valid, act_last, busy, done} !== 4'b0)
            $display("FAIL reset_flags got %b exp 0000", {act_valid, act_last, busy, done}); else n_pass++;
        n_total++; if (act_data !== 0) $display("FAIL reset_act_data got %h exp 0", act_data); else n_pass++;
        rst = 0; next();
        n_total++; if (rdata !== 32'h8) $display("FAIL reset_status got %h exp 00000008", rdata); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] exp_w[3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 3; i++) push(exp_w[i]);
        write_type(32'h8000_0003);
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_start got %b exp 1", busy); else n_pass++;
        collect(3, 1'b0);
        n_total++; if (got_d.size() != 3) $display("FAIL basic_count got %0d exp 3", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size(); i++) begin
            n_total++;
            if (got_d[i] !== exp_w[i] || got_l[i] !== (i == 2))
                $display("FAIL basic_word%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_w[i], i == 2);
            else n_pass++;
        end
        n_total++; if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL basic_wait got busy=%b done=%b exp 1/0", busy, done); else n_pass++;
        finish_job(32'hABCD);
        n_total++; if (busy !== 1'b0 || done !== 1'b1)
            $display("FAIL basic_done got busy=%b done=%b exp 0/1", busy, done); else n_pass++;
        read_reg(2, v);
        n_total++; if (v !== 32'h0000_ABCD) $display("FAIL basic_result got %h exp 0000abcd", v); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL basic_done_clear got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_q[$];
        logic [31:0] w, v, held, r;
        int n, extra, got, cyc;
        bit hold;
        for (int run = 0; run < 4; run++) begin
            do_reset();
            exp_q.delete();
            n = $urandom_range(1, 8);
            extra = $urandom_range(0, 3);
            for (int i = 0; i < n + extra; i++) begin
                w = $urandom; exp_q.push_back(w); push(w);
            end
            write_type(32'h8000_0000 | 32'(n));
            got = 0; cyc = 0; hold = 0; held = 0;
            while (got < n && cyc < 300) begin
                act_ready = 1'($urandom_range(0, 1));
                #1;
                if (hold) begin
                    n_total++;
                    if (act_valid !== 1'b1 || act_data !== held)
                        $display("FAIL rnd_hold got %b/%h exp 1/%h", act_valid, act_data, held);
                    else n_pass++;
                end
                hold = act_valid && !act_ready;
                held = act_data;
                if (act_valid && act_ready) begin
                    n_total++;
                    if (act_data !== exp_q[0] || act_last !== (got == n - 1))
                        $display("FAIL rnd_word%0d got %h/%b exp %h/%b", got, act_data, act_last, exp_q[0], got == n - 1);
                    else n_pass++;
                    void'(exp_q.pop_front());
                    got++;
                end
                next(); cyc++;
            end
            act_ready = 0;
            n_total++; if (got != n) $display("FAIL rnd_timeout got %0d words exp %0d", got, n); else n_pass++;
            read_reg(3, v);
            n_total++;
            if (v !== (32'h1 | (extra == 0 ? 32'h8 : 32'h0) | (32'(extra) << 8)))
                $display("FAIL rnd_status got %h exp busy with %0d left", v, extra);
            else n_pass++;
            r = $urandom;
            finish_job(r);
            read_reg(2, v);
            n_total++; if (v !== r) $display("FAIL rnd_result got %h exp %h", v, r); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin w[i] = $urandom; push(w[i]); end
        write_type(32'h8000_0004);
        act_ready = 1; #1;
        n_total++; if (act_data !== w[0]) $display("FAIL bp_first got %h exp %h", act_data, w[0]); else n_pass++;
        next();
        act_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++;
            if (act_valid !== 1'b1 || act_data !== w[1])
                $display("FAIL bp_hold%0d got %b/%h exp 1/%h", c, act_valid, act_data, w[1]);
            else n_pass++;
            if (c > 0) begin
                n_total++;
                if (rdata[15:8] !== 8'd3) $display("FAIL bp_count%0d got %0d exp 3", c, rdata[15:8]); else n_pass++;
            end
            next();
        end
        collect(3, 1'b0);
        n_total++; if (got_d.size() != 3) $display("FAIL bp_drain got %0d exp 3", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size(); i++) begin
            n_total++;
            if (got_d[i] !== w[i + 1] || got_l[i] !== (i == 2))
                $display("FAIL bp_word%0d got %h/%b exp %h/%b", i + 1, got_d[i], got_l[i], w[i + 1], i == 2);
            else n_pass++;
        end
        finish_job(32'h1);
    endtask

    task automatic test_overflow();
        logic [31:0] w[DEPTH + 1];
        logic [31:0] v;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin w[i] = $urandom; push(w[i]); end
        read_reg(3, v);
        n_total++; if (v !== 32'h0000_1014) $display("FAIL ovf_status got %h exp 00001014", v); else n_pass++;
        write_type(32'h0000_0010);
        read_reg(3, v);
        n_total++; if (v !== 32'h0000_1004) $display("FAIL ovf_clear got %h exp 00001004", v); else n_pass++;
        read_reg(0, v);
        n_total++; if (v !== 32'h0000_0010) $display("FAIL ovf_type_rd got %h exp 00000010", v); else n_pass++;
        write_type(32'h8000_0010);
        collect(DEPTH, 1'b1);
        n_total++; if (got_d.size() != DEPTH) $display("FAIL ovf_drain got %0d exp %0d", got_d.size(), DEPTH); else n_pass++;
        for (int i = 0; i < got_d.size(); i++) begin
            n_total++;
            if (got_d[i] !== w[i] || got_l[i] !== (i == DEPTH - 1))
                $display("FAIL ovf_word%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], w[i], i == DEPTH - 1);
            else n_pass++;
        end
        read_reg(3, v);
        n_total++; if (v !== 32'h0000_0009) $display("FAIL ovf_after got %h exp 00000009", v); else n_pass++;
        finish_job(32'h2);
    endtask

    task automatic test_empty_start();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        do_reset();
        write_type(32'h8000_0002);
        act_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (act_valid !== 1'b0) $display("FAIL es_idle%0d got %b exp 0", c, act_valid); else n_pass++;
            next();
        end
        wen_input = 1; wdata = a; #1;
        n_total++; if (act_valid !== 1'b0) $display("FAIL es_push_cycle got %b exp 0", act_valid); else n_pass++;
        next();
        wdata = b; #1;
        n_total++;
        if (act_valid !== 1'b1 || act_data !== a || act_last !== 1'b0)
            $display("FAIL es_head got %b/%h/%b exp 1/%h/0", act_valid, act_data, act_last, a);
        else n_pass++;
        next();
        wen_input = 0; #1;
        n_total++;
        if (act_valid !== 1'b1 || act_data !== b || act_last !== 1'b1)
            $display("FAIL es_second got %b/%h/%b exp 1/%h/1", act_valid, act_data, act_last, b);
        else n_pass++;
        next();
        act_ready = 0;
        n_total++; if (rdata[15:8] !== 8'd1) $display("FAIL es_pushpop_count got %0d exp 1", rdata[15:8]); else n_pass++;
        n_total++; if (busy !== 1'b1 || act_valid !== 1'b0)
            $display("FAIL es_wait got %b/%b exp 1/0", busy, act_valid); else n_pass++;
        finish_job(32'h3);
    endtask

    task automatic test_ignored();
        logic [31:0] w[3];
        logic [31:0] v;
        do_reset();
        write_type(32'h8000_0002);
        write_type(32'h8000_0005);
        for (int i = 0; i < 3; i++) begin w[i] = $urandom; push(w[i]); end
        collect(2, 1'b0);
        n_total++; if (got_d.size() != 2) $display("FAIL ign_count got %0d exp 2", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size(); i++) begin
            n_total++;
            if (got_d[i] !== w[i] || got_l[i] !== (i == 1))
                $display("FAIL ign_word%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], w[i], i == 1);
            else n_pass++;
        end
        #1;
        n_total++; if (act_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL ign_wait got valid=%b busy=%b exp 0/1", act_valid, busy); else n_pass++;
        read_reg(0, v);
        n_total++; if (v !== 32'h2) $display("FAIL ign_len got %h exp 00000002", v); else n_pass++;
        finish_job(32'h5555);
        read_reg(2, v);
        n_total++; if (v !== 32'h5555) $display("FAIL ign_result got %h exp 00005555", v); else n_pass++;
        finish_job(32'h1234);
        n_total++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL ign_idle_res got done=%b busy=%b exp 0/0", done, busy); else n_pass++;
        read_reg(2, v);
        n_total++; if (v !== 32'h5555) $display("FAIL ign_result_kept got %h exp 00005555", v); else n_pass++;
        write_type(32'h8000_0000);
        n_total++; if (busy !== 1'b0) $display("FAIL ign_len0 got %b exp 0", busy); else n_pass++;
        read_reg(3, v);
        n_total++; if (v !== 32'h0000_0100) $display("FAIL ign_status got %h exp 00000100", v); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push($urandom); push($urandom);
        write_type(32'h8000_0004);
        collect(1, 1'b0);
        n_total++; if (busy !== 1'b1) $display("FAIL rm_busy got %b exp 1", busy); else n_pass++;
        rst = 1; next();
        #1;
        n_total++; if ({busy, act_valid, done} !== 3'b0)
            $display("FAIL rm_flags got %b exp 000", {busy, act_valid, done}); else n_pass++;
        rst = 0; next();
        n_total++; if (rdata !== 32'h8) $display("FAIL rm_status got %h exp 00000008", rdata); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        test_reset();
        test_basic();
        test_random_stream();
        test_backpressure();
        test_overflow();
        test_empty_start();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
